// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD_CTRL command path: command encodings,
// command-master state encodings and image geometry.
package lcd_pkg;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_SHUP  = 3'd1;
    localparam logic [2:0] CMD_SHDN  = 3'd2;
    localparam logic [2:0] CMD_SHL   = 3'd3;
    localparam logic [2:0] CMD_SHR   = 3'd4;
    localparam logic [2:0] CMD_AVG   = 3'd5;
    localparam logic [2:0] CMD_MIRX  = 3'd6;
    localparam logic [2:0] CMD_MIRY  = 3'd7;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_FETCH     = 3'd1;
    localparam state_t ST_LATCH     = 3'd2;
    localparam state_t ST_ISSUE     = 3'd3;
    localparam state_t ST_GAP       = 3'd4;
    localparam state_t ST_WAIT_DONE = 3'd5;
    localparam state_t ST_FINISH    = 3'd6;

    localparam int IMG_DIM = 8;
    localparam int IMG_N   = IMG_DIM * IMG_DIM;

endpackage

// File: rtl/lcd_cmd_wdog.sv
// Watchdog counter for the command master: counts enabled cycles and flags
// the last permitted cycle so the master can give up on that same edge.
module lcd_cmd_wdog
    import lcd_pkg::*;
#(
    parameter int CNT_W       = 13,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive waiting cycle.
    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/lcd_cmd_master.sv
// Fetches a command list from the CROM and feeds it to LCD_CTRL over the
// busy/cmd_valid handshake, then waits for done and reports the outcome.
module lcd_cmd_master
    import lcd_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   n_cmd,
    output logic              CROM_EN,
    output logic [ADDR_W-1:0] CROM_A,
    input  logic [2:0]        CROM_Q,
    output logic [2:0]        cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              done,
    output logic              running,
    output logic              finished,
    output logic              timeout,
    output logic              err,
    output logic [ADDR_W:0]   issued_cnt
);

    state_t          state;
    logic [ADDR_W:0] n_cmd_r;
    logic            wd_en;
    logic            wd_clr;
    logic            wd_exp;

    // The watchdog only runs while we sit in a waiting state; any other cycle
    // is either a state change or a state where waiting is not bounded.
    assign wd_en  = ((state == ST_ISSUE) && busy) || ((state == ST_WAIT_DONE) && !done);
    assign wd_clr = !wd_en || wd_exp;

    lcd_cmd_wdog #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            n_cmd_r    <= '0;
            CROM_EN    <= 1'b1;
            CROM_A     <= '0;
            cmd        <= CMD_WRITE;
            cmd_valid  <= 1'b0;
            running    <= 1'b0;
            finished   <= 1'b0;
            timeout    <= 1'b0;
            err        <= 1'b0;
            issued_cnt <= '0;
        end else begin
            cmd_valid <= 1'b0;

            // A stray done is recorded but does not stop the run; a start
            // accepted below in the same cycle overrides it.
            if (done && (state != ST_WAIT_DONE) && (state != ST_FINISH)) begin
                err <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        n_cmd_r    <= n_cmd;
                        issued_cnt <= '0;
                        timeout    <= 1'b0;
                        CROM_A     <= '0;
                        if (n_cmd == '0) begin
                            err      <= 1'b1;
                            finished <= 1'b1;
                            running  <= 1'b0;
                            state    <= ST_FINISH;
                        end else begin
                            err      <= 1'b0;
                            finished <= 1'b0;
                            running  <= 1'b1;
                            CROM_EN  <= 1'b0;
                            state    <= ST_FETCH;
                        end
                    end
                end

                ST_FETCH: begin
                    CROM_EN <= 1'b1;
                    state   <= ST_LATCH;
                end

                ST_LATCH: begin
                    cmd   <= CROM_Q;
                    state <= ST_ISSUE;
                end

                ST_ISSUE: begin
                    if (!busy) begin
                        cmd_valid  <= 1'b1;
                        issued_cnt <= issued_cnt + 1'b1;
                        state      <= ST_GAP;
                    end else if (wd_exp) begin
                        timeout  <= 1'b1;
                        running  <= 1'b0;
                        finished <= 1'b1;
                        state    <= ST_FINISH;
                    end
                end

                // busy is not looked at here: LCD_CTRL raises it on the edge
                // that accepts the command, so it is not yet meaningful.
                ST_GAP: begin
                    if (cmd == CMD_WRITE) begin
                        state <= ST_WAIT_DONE;
                    end else if (issued_cnt == n_cmd_r) begin
                        err      <= 1'b1;
                        running  <= 1'b0;
                        finished <= 1'b1;
                        state    <= ST_FINISH;
                    end else begin
                        CROM_A  <= CROM_A + 1'b1;
                        CROM_EN <= 1'b0;
                        state   <= ST_FETCH;
                    end
                end

                ST_WAIT_DONE: begin
                    if (done) begin
                        running  <= 1'b0;
                        finished <= 1'b1;
                        state    <= ST_FINISH;
                    end else if (wd_exp) begin
                        timeout  <= 1'b1;
                        running  <= 1'b0;
                        finished <= 1'b1;
                        state    <= ST_FINISH;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
